// File: rtl/agc_pkg.sv
// Shared definitions for the AGC memory arbiter: ones'-complement constants,
// FSM state encoding, queue entry layout and the end-around-carry adder.
package agc_pkg;

  localparam int DW     = 15;
  localparam int MEM_AW = 12;
  localparam int CNT_AW = 10;

  localparam logic [DW-1:0] OC_PZERO = 15'h0000;
  localparam logic [DW-1:0] OC_MZERO = 15'h7FFF;
  localparam logic [DW-1:0] OC_PMAX  = 15'h3FFF;
  localparam logic [DW-1:0] OC_MMAX  = 15'h4000;
  localparam logic [DW-1:0] OC_PONE  = 15'h0001;
  localparam logic [DW-1:0] OC_MONE  = 15'h7FFE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CTRL = 2'd1,
    ST_CRD  = 2'd2,
    ST_CWR  = 2'd3
  } agc_state_e;

  typedef struct packed {
    logic              dir;
    logic [CNT_AW-1:0] addr;
  } cnt_req_t;

  typedef struct packed {
    agc_state_e  state;
    logic        fifo_empty;
    logic        fifo_full;
    logic [7:0]  starve_cnt;
  } agc_dbg_t;

  // 15-bit ones'-complement add: the carry out of bit 14 is folded back in.
  function automatic logic [DW-1:0] oc_add15(input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW-1:0] + {{(DW-1){1'b0}}, s[DW]};
  endfunction

endpackage

// File: rtl/cnt_fifo.sv
// Synchronous FIFO for posted counter increments; the ready flag is a register
// tracking next-cycle occupancy so producers see a glitch-free accept window.
module cnt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic         ready
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ready_q, ready_d;
  logic          push_en, pop_en;

  always_comb begin
    push_en  = push & ready_q;
    pop_en   = pop & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign ready = ready_q;

endmodule

// File: rtl/agc_mem_arbiter.sv
// Shares the AGC memory port between control-unit accesses and queued
// PINC/MINC counter increments, run as atomic read-modify-write pairs.
module agc_mem_arbiter
  import agc_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_req,
  input  logic              ctrl_we,
  input  logic [MEM_AW-1:0] ctrl_addr,
  input  logic [DW-1:0]     ctrl_wdata,
  output logic              ctrl_gnt,
  output logic [DW-1:0]     ctrl_rdata,
  input  logic              cnt_valid,
  input  logic              cnt_dir,
  input  logic [CNT_AW-1:0] cnt_addr,
  output logic              cnt_ready,
  output logic              cnt_ovf,
  output logic [CNT_AW-1:0] cnt_ovf_addr,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_din,
  input  logic [DW-1:0]     mem_dout,
  output agc_dbg_t          dbg
);

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  // Handshakes: a counter request transfers on a cycle where cnt_valid and
  // cnt_ready are both high; ctrl_req is held until the single-cycle ctrl_gnt,
  // and the access happens on exactly that grant cycle.

  agc_state_e        state_q, state_d;
  logic [7:0]        starve_q, starve_d;
  logic              ctrl_we_q, ctrl_we_d;
  logic [MEM_AW-1:0] ctrl_addr_q, ctrl_addr_d;
  logic [DW-1:0]     ctrl_wdata_q, ctrl_wdata_d;
  logic [DW-1:0]     cnt_val_q, cnt_val_d;

  cnt_req_t    push_req;
  cnt_req_t    head;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        starve_hit;
  logic        pinc;
  logic [DW-1:0] inc_sum;
  logic [DW-1:0] inc_res;
  logic        inc_wrap;

  assign push_req = '{dir: cnt_dir, addr: cnt_addr};

  cnt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(cnt_req_t))
  ) u_cnt_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cnt_valid),
    .wdata (push_req),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ready (cnt_ready)
  );

  // Counters are 14-bit magnitudes: crossing +max or -max is an overflow and
  // leaves the matching zero behind instead of flipping the sign.
  always_comb begin
    pinc     = ~head.dir;
    inc_sum  = oc_add15(cnt_val_q, pinc ? OC_PONE : OC_MONE);
    inc_wrap = pinc ? (~cnt_val_q[DW-1] & inc_sum[DW-1])
                    : (cnt_val_q[DW-1] & ~inc_sum[DW-1]);
    inc_res  = inc_sum;
    if (inc_wrap) inc_res = pinc ? OC_PZERO : OC_MZERO;
  end

  assign starve_hit = (starve_q >= STARVE_MAX);

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    ctrl_we_d    = ctrl_we_q;
    ctrl_addr_d  = ctrl_addr_q;
    ctrl_wdata_d = ctrl_wdata_q;
    cnt_val_d    = cnt_val_q;
    fifo_pop     = 1'b0;
    ctrl_gnt     = 1'b0;
    ctrl_rdata   = '0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_din      = '0;
    cnt_ovf      = 1'b0;
    cnt_ovf_addr = '0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && (!ctrl_req || starve_hit)) begin
          state_d = ST_CRD;
        end else if (ctrl_req) begin
          state_d      = ST_CTRL;
          ctrl_we_d    = ctrl_we;
          ctrl_addr_d  = ctrl_addr;
          ctrl_wdata_d = ctrl_wdata;
        end
      end
      ST_CTRL: begin
        ctrl_gnt = 1'b1;
        mem_we   = ctrl_we_q;
        mem_addr = ctrl_addr_q;
        mem_din  = ctrl_wdata_q;
        if (!ctrl_we_q) ctrl_rdata = mem_dout;
        state_d  = ST_IDLE;
      end
      ST_CRD: begin
        mem_addr  = {{(MEM_AW - CNT_AW){1'b0}}, head.addr};
        cnt_val_d = mem_dout;
        state_d   = ST_CWR;
      end
      ST_CWR: begin
        // Reset landing on this cycle must abandon the write and its ovf pulse.
        mem_we   = rst_n;
        mem_addr = {{(MEM_AW - CNT_AW){1'b0}}, head.addr};
        mem_din  = inc_res;
        fifo_pop = 1'b1;
        cnt_ovf  = inc_wrap & rst_n;
        if (cnt_ovf) cnt_ovf_addr = head.addr;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_CRD && state_q != ST_CRD) begin
      starve_d = '0;
    end else if (!fifo_empty && (state_q == ST_IDLE || state_q == ST_CTRL)
                 && !starve_hit) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      starve_q     <= '0;
      ctrl_we_q    <= 1'b0;
      ctrl_addr_q  <= '0;
      ctrl_wdata_q <= '0;
      cnt_val_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      ctrl_we_q    <= ctrl_we_d;
      ctrl_addr_q  <= ctrl_addr_d;
      ctrl_wdata_q <= ctrl_wdata_d;
      cnt_val_q    <= cnt_val_d;
    end
  end

  always_comb begin
    dbg            = '0;
    dbg.state      = state_q;
    dbg.fifo_empty = fifo_empty;
    dbg.fifo_full  = fifo_full;
    dbg.starve_cnt = starve_q;
  end

endmodule

// File: tb/tb_agc_mem_arbiter.sv
// Directed bench for agc_mem_arbiter with a behavioural memory model and
// hand-computed expected values for ctrl accesses and counter increments.
module tb_agc_mem_arbiter;
  import agc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctrl_req, ctrl_we, ctrl_gnt;
  logic [11:0] ctrl_addr;
  logic [14:0] ctrl_wdata, ctrl_rdata;
  logic        cnt_valid, cnt_dir, cnt_ready, cnt_ovf;
  logic [9:0]  cnt_addr, cnt_ovf_addr;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [14:0] mem_din, mem_dout;
  agc_dbg_t    dbg;

  // clock / reset
  always #5 clk = ~clk;

  agc_mem_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_req(ctrl_req), .ctrl_we(ctrl_we), .ctrl_addr(ctrl_addr),
    .ctrl_wdata(ctrl_wdata), .ctrl_gnt(ctrl_gnt), .ctrl_rdata(ctrl_rdata),
    .cnt_valid(cnt_valid), .cnt_dir(cnt_dir), .cnt_addr(cnt_addr),
    .cnt_ready(cnt_ready), .cnt_ovf(cnt_ovf), .cnt_ovf_addr(cnt_ovf_addr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .dbg(dbg)
  );

  // memory model with a preload port used only while the DUT is idle
  logic [14:0] mem [4096];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [14:0] pre_data;

  assign mem_dout = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  // scoreboard
  logic [11:0] exp_q[$];
  logic [11:0] exp_addr;
  int n_tests = 0;
  int n_fail  = 0;
  int idx, n_cwr, first_gnt, first_cwr, ready_low_at, n_gnt_pre, gnt_atomic;
  logic acc;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [11:0] a, input logic [14:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic do_cnt(input string tag, input logic dir, input logic [9:0] a,
                        input logic [14:0] init, input logic [14:0] expv,
                        input logic exp_ovf);
    poke({2'b00, a}, init);
    cnt_valid = 1'b1; cnt_dir = dir; cnt_addr = a;
    tick();
    cnt_valid = 1'b0;
    tick();
    check({tag, "_crd_state"}, dbg.state, ST_CRD);
    check({tag, "_crd_addr"}, mem_addr, {2'b00, a});
    tick();
    check({tag, "_cwr_we"}, mem_we, 1'b1);
    check({tag, "_cwr_din"}, mem_din, expv);
    check({tag, "_ovf"}, cnt_ovf, exp_ovf);
    check({tag, "_ovf_addr"}, cnt_ovf_addr, exp_ovf ? a : 10'd0);
    tick();
    check({tag, "_mem"}, mem[{2'b00, a}], expv);
    check({tag, "_ovf_pulse_end"}, cnt_ovf, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ctrl_req = 1'b0; ctrl_we = 1'b0; ctrl_addr = '0;
    ctrl_wdata = '0; cnt_valid = 1'b0; cnt_dir = 1'b0; cnt_addr = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset values
    check("rst_gnt", ctrl_gnt, 1'b0);
    check("rst_ready", cnt_ready, 1'b1);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 12'd0);
    check("rst_ovf", cnt_ovf, 1'b0);
    check("rst_state", dbg.state, ST_IDLE);
    check("rst_starve", dbg.starve_cnt, 8'd0);

    // ctrl read, no counters pending
    poke(12'h002, 15'h0123);
    ctrl_req = 1'b1; ctrl_we = 1'b0; ctrl_addr = 12'h002;
    check("rd_no_early_gnt", ctrl_gnt, 1'b0);
    tick();
    check("rd_gnt", ctrl_gnt, 1'b1);
    check("rd_data", ctrl_rdata, 15'h0123);
    ctrl_req = 1'b0;
    tick();
    check("rd_gnt_pulse", ctrl_gnt, 1'b0);

    // ctrl write
    ctrl_req = 1'b1; ctrl_we = 1'b1; ctrl_addr = 12'h005; ctrl_wdata = 15'h1555;
    tick();
    check("wr_gnt", ctrl_gnt, 1'b1);
    check("wr_mem_we", mem_we, 1'b1);
    check("wr_mem_addr", mem_addr, 12'h005);
    check("wr_rdata_zero", ctrl_rdata, 15'h0000);
    ctrl_req = 1'b0; ctrl_we = 1'b0;
    tick();
    check("wr_mem", mem[12'h005], 15'h1555);

    // counter increments
    do_cnt("pinc_wrap", 1'b0, 10'h024, 15'h3FFF, 15'h0000, 1'b1);
    do_cnt("pinc_mzero", 1'b0, 10'h025, 15'h7FFF, 15'h0001, 1'b0);
    do_cnt("pinc_plain", 1'b0, 10'h028, 15'h0005, 15'h0006, 1'b0);
    do_cnt("minc_pzero", 1'b1, 10'h026, 15'h0000, 15'h7FFE, 1'b0);
    do_cnt("minc_wrap", 1'b1, 10'h027, 15'h4000, 15'h7FFF, 1'b1);

    // starvation guard: ctrl held, one counter pending
    poke(12'h040, 15'h0100);
    ctrl_req = 1'b1; ctrl_we = 1'b0; ctrl_addr = 12'h003;
    cnt_valid = 1'b1; cnt_dir = 1'b0; cnt_addr = 10'h040;
    first_cwr = -1; n_gnt_pre = 0; gnt_atomic = 0;
    for (int cyc = 0; cyc < 40 && first_cwr < 0; cyc++) begin
      if (ctrl_gnt) n_gnt_pre++;
      if (ctrl_gnt && (dbg.state == ST_CRD || dbg.state == ST_CWR)) gnt_atomic++;
      if (dbg.state == ST_CWR && mem_we) first_cwr = cyc;
      tick();
      cnt_valid = 1'b0;
    end
    check("starve_cwr_cycle", first_cwr, 12);
    check("starve_gnts_before", n_gnt_pre, 5);
    check("starve_no_gnt_atomic", gnt_atomic, 0);
    check("starve_mem", mem[12'h040], 15'h0101);
    for (int k = 0; k < 10 && !ctrl_gnt; k++) tick();
    check("starve_gnt_resumes", ctrl_gnt, 1'b1);
    ctrl_req = 1'b0;
    tick();

    // five back-to-back requests with ctrl held: queue fills, none lost
    for (int i = 0; i < 5; i++) begin
      poke(12'h100 + 12'(i), 15'h0010 + 15'(i));
      exp_q.push_back(12'h100 + 12'(i));
    end
    ctrl_req = 1'b1; ctrl_we = 1'b0; ctrl_addr = 12'h002;
    idx = 0; n_cwr = 0; first_gnt = -1; first_cwr = -1; ready_low_at = -1;
    for (int cyc = 0; cyc < 300 && n_cwr < 5; cyc++) begin
      if (ctrl_gnt && first_gnt < 0) first_gnt = cyc;
      if (dbg.state == ST_CWR && mem_we) begin
        n_cwr++;
        if (first_cwr < 0) first_cwr = cyc;
        exp_addr = exp_q.pop_front();
        check("fill_order", mem_addr, exp_addr);
      end
      if (!cnt_ready && ready_low_at < 0) ready_low_at = idx;
      if (idx < 5) begin
        cnt_valid = 1'b1; cnt_dir = 1'b0; cnt_addr = 10'h100 + 10'(idx);
      end else begin
        cnt_valid = 1'b0;
      end
      acc = cnt_valid & cnt_ready;
      tick();
      if (acc) idx++;
    end
    cnt_valid = 1'b0;
    check("fill_all_served", n_cwr, 5);
    check("fill_ready_low_after", ready_low_at, 4);
    check("fill_after_gnt", (first_gnt >= 0) && (first_cwr > first_gnt), 1'b1);
    check("fill_queue_drained", exp_q.size(), 0);
    for (int k = 0; k < 20 && !ctrl_gnt; k++) tick();
    ctrl_req = 1'b0;
    tick();
    for (int i = 0; i < 5; i++)
      check("fill_mem", mem[12'h100 + 12'(i)], 15'h0011 + 15'(i));

    // reset during CWR with three queued entries
    poke(12'h030, 15'h3FFF);
    poke(12'h031, 15'h0001);
    poke(12'h032, 15'h0002);
    cnt_valid = 1'b1; cnt_dir = 1'b0; cnt_addr = 10'h030;
    tick();
    cnt_addr = 10'h031;
    tick();
    cnt_addr = 10'h032;
    tick();
    cnt_valid = 1'b0;
    check("rcwr_in_cwr", dbg.state, ST_CWR);
    rst_n = 1'b0;
    #1;
    check("rcwr_no_ovf", cnt_ovf, 1'b0);
    check("rcwr_no_we", mem_we, 1'b0);
    tick();
    rst_n = 1'b1;
    check("rcwr_state", dbg.state, ST_IDLE);
    check("rcwr_empty", dbg.fifo_empty, 1'b1);
    check("rcwr_ready", cnt_ready, 1'b1);
    check("rcwr_word", mem[12'h030], 15'h3FFF);
    repeat (3) tick();
    check("rcwr_stays_idle", dbg.state, ST_IDLE);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
